// File: rtl/disteu_pkg.sv
// Shared types and constants for the disteu match controller: FSM state
// encoding, disteu mode field values and the distance word width.
package disteu_pkg;

    localparam int DIST_W = 30;

    localparam logic [1:0] MODE_ONE_TO_ONE   = 2'b00;
    localparam logic [1:0] MODE_ONE_TO_MANY  = 2'b01;
    localparam logic [1:0] MODE_MANY_TO_MANY = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        WAIT_RES,
        COMPARE,
        DONE
    } state_t;

endpackage

// File: rtl/disteu_min_track.sv
// Running minimum over speaker distances; the first candidate of a job always
// loads, later ones replace only on strictly smaller distance.
module disteu_min_track
    import disteu_pkg::*;
#(
    parameter int ID_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              update,
    input  logic [ID_W-1:0]   cand_id,
    input  logic [DIST_W-1:0] cand_dist,
    output logic [ID_W-1:0]   best_id,
    output logic [DIST_W-1:0] best,
    output logic [ID_W-1:0]   best_id_next,
    output logic [DIST_W-1:0] best_next
);

    logic              take;
    logic [ID_W-1:0]   best_id_reg;
    logic [DIST_W-1:0] best_reg;

    assign take         = update && ((cand_id == '0) || (cand_dist < best_reg));
    assign best_next    = take ? cand_dist : best_reg;
    assign best_id_next = take ? cand_id : best_id_reg;
    assign best         = best_reg;
    assign best_id      = best_id_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_reg    <= '0;
            best_id_reg <= '0;
        end else if (clear) begin
            best_reg    <= '0;
            best_id_reg <= '0;
        end else begin
            best_reg    <= best_next;
            best_id_reg <= best_id_next;
        end
    end

endmodule

// File: rtl/disteu_match_ctrl.sv
// Sequences one disteu many-to-many run per speaker codebook and reports the
// closest speaker. Define DISTEU_CTRL_TIMEOUT_EN to add a CFG/WAIT_RES watchdog.
module disteu_match_ctrl
    import disteu_pkg::*;
#(
    parameter int MEAN_FRAME_WIDTH = 9,
    parameter int NUM_SPK          = 4,
    parameter int CB_COLS          = 16,
    parameter int TIMEOUT_CYC      = 65535,
    localparam int SPK_W           = (NUM_SPK > 1) ? $clog2(NUM_SPK) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [MEAN_FRAME_WIDTH-1:0] frame_num,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [SPK_W-1:0]            spk_id,
    output logic [DIST_W-1:0]           best_dist,
    output logic [SPK_W-1:0]            cb_sel,
    output logic                        cfg_valid,
    output logic [MEAN_FRAME_WIDTH-1:0] cfg_data,
    output logic                        cfg_last,
    output logic [5:0]                  cfg_mode_data,
    input  logic                        dist_ready,
    input  logic                        dist_valid,
    input  logic [DIST_W-1:0]           dist_data
);

    state_t                      state_reg, state_next;
    logic [MEAN_FRAME_WIDTH-1:0] fn_reg;
    logic [MEAN_FRAME_WIDTH-1:0] idx_reg;
    logic [SPK_W-1:0]            k_reg;
    logic [DIST_W-1:0]           cap_reg;
    logic                        gap_reg;
    logic                        err_reg;
    logic [SPK_W-1:0]            spk_id_reg;
    logic [DIST_W-1:0]           best_dist_reg;

    logic                        beat;
    logic                        last_beat;
    logic                        last_spk;
    logic                        timeout;
    logic [SPK_W-1:0]            best_id, best_id_next;
    logic [DIST_W-1:0]           best, best_next;

    // The first CFG cycle after a COMPARE is held empty so disteu can re-init.
    assign beat      = (state_reg == CFG) && !gap_reg && dist_ready;
    assign last_beat = beat && (idx_reg == fn_reg - 1'b1);
    assign last_spk  = (k_reg == SPK_W'(NUM_SPK - 1));

    disteu_min_track #(
        .ID_W (SPK_W)
    ) u_min_track (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        ((state_reg == IDLE) && start),
        .update       (state_reg == COMPARE),
        .cand_id      (k_reg),
        .cand_dist    (cap_reg),
        .best_id      (best_id),
        .best         (best),
        .best_id_next (best_id_next),
        .best_next    (best_next)
    );

`ifdef DISTEU_CTRL_TIMEOUT_EN
    logic [31:0] to_cnt_reg;

    assign timeout = ((state_reg == CFG) || (state_reg == WAIT_RES))
                     && (to_cnt_reg == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_reg <= '0;
        end else if ((state_next != state_reg) || beat) begin
            to_cnt_reg <= '0;
        end else if ((state_reg == CFG) || (state_reg == WAIT_RES)) begin
            to_cnt_reg <= to_cnt_reg + 32'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (frame_num == '0) ? DONE : CFG;
                end
            end
            CFG: begin
                if (last_beat) begin
                    state_next = WAIT_RES;
                end else if (timeout && !beat) begin
                    state_next = DONE;
                end
            end
            WAIT_RES: begin
                if (dist_valid) begin
                    state_next = COMPARE;
                end else if (timeout) begin
                    state_next = DONE;
                end
            end
            COMPARE: state_next = last_spk ? DONE : CFG;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            fn_reg        <= '0;
            idx_reg       <= '0;
            k_reg         <= '0;
            cap_reg       <= '0;
            gap_reg       <= 1'b0;
            err_reg       <= 1'b0;
            spk_id_reg    <= '0;
            best_dist_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        fn_reg  <= frame_num;
                        idx_reg <= '0;
                        k_reg   <= '0;
                        gap_reg <= 1'b0;
                    end
                end
                CFG: begin
                    gap_reg <= 1'b0;
                    if (beat) begin
                        idx_reg <= last_beat ? '0 : idx_reg + 1'b1;
                    end
                end
                WAIT_RES: begin
                    if (dist_valid) begin
                        cap_reg <= dist_data;
                    end
                end
                COMPARE: begin
                    if (!last_spk) begin
                        k_reg   <= k_reg + 1'b1;
                        gap_reg <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Result registers load on DONE entry and hold until the next job ends.
            if (state_next == DONE) begin
                if (state_reg == COMPARE) begin
                    err_reg       <= 1'b0;
                    spk_id_reg    <= best_id_next;
                    best_dist_reg <= best_next;
                end else if (state_reg == IDLE) begin
                    err_reg       <= 1'b1;
                    spk_id_reg    <= '0;
                    best_dist_reg <= '0;
                end else begin
                    err_reg       <= 1'b1;
                    spk_id_reg    <= best_id;
                    best_dist_reg <= best;
                end
            end
        end
    end

    assign busy          = (state_reg == CFG) || (state_reg == WAIT_RES) || (state_reg == COMPARE);
    assign done          = (state_reg == DONE);
    assign err           = err_reg;
    assign spk_id        = spk_id_reg;
    assign best_dist     = best_dist_reg;
    assign cb_sel        = k_reg;
    assign cfg_valid     = beat;
    assign cfg_last      = last_beat;
    assign cfg_data      = idx_reg;
    assign cfg_mode_data = {MODE_MANY_TO_MANY, 4'(CB_COLS - 1)};

endmodule

// File: tb/tb_disteu_match_ctrl.sv
// Self-checking bench for disteu_match_ctrl: randomized jobs against a
// behavioural model of the speaker search, plus directed corner scenarios.
module tb_disteu_match_ctrl;

    localparam int MFW  = 9;
    localparam int NSPK = 4;
    localparam int CBC  = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [MFW-1:0] frame_num = '0;
    logic           dist_ready = 1'b0;
    logic           dist_valid = 1'b0;
    logic [29:0]    dist_data = '0;
    logic           busy, done, err, cfg_valid, cfg_last;
    logic [1:0]     spk_id, cb_sel;
    logic [29:0]    best_dist;
    logic [MFW-1:0] cfg_data;
    logic [5:0]     cfg_mode_data;

    disteu_match_ctrl #(
        .MEAN_FRAME_WIDTH (MFW),
        .NUM_SPK          (NSPK),
        .CB_COLS          (CBC),
        .TIMEOUT_CYC      (65535)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .frame_num     (frame_num),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .spk_id        (spk_id),
        .best_dist     (best_dist),
        .cb_sel        (cb_sel),
        .cfg_valid     (cfg_valid),
        .cfg_data      (cfg_data),
        .cfg_last      (cfg_last),
        .cfg_mode_data (cfg_mode_data),
        .dist_ready    (dist_ready),
        .dist_valid    (dist_valid),
        .dist_data     (dist_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Observations gathered by drive_job, judged by each test task.
    int          obs_beats[$];
    int          obs_beat_spk[$];
    int          obs_last_cnt, obs_last_bad, obs_cbsel_bad, obs_gap_bad;
    int          obs_done_cnt, obs_resp_cnt, obs_done_cyc;
    logic [1:0]  obs_spk;
    logic [29:0] obs_best;
    logic        obs_err, obs_busy_at_done, obs_busy1;
    bit          obs_timeout;
    logic [29:0] dists[NSPK];

    // Winner = smallest distance, earliest speaker among equals.
    task automatic ref_result(input int fn, output logic [1:0] sid, output logic [29:0] bd, output logic e);
        logic [29:0] m;
        m = dists[0];
        for (int i = 1; i < NSPK; i++) if (dists[i] < m) m = dists[i];
        sid = 2'd0;
        for (int i = NSPK - 1; i >= 0; i--) if (dists[i] == m) sid = 2'(i);
        bd = m;
        e  = 1'b0;
        if (fn == 0) begin
            sid = 2'd0;
            bd  = '0;
            e   = 1'b1;
        end
    endtask

    // ready_mode: 0 always ready, 1 toggling, 2 random.
    task automatic drive_job(input int fn, input int ready_mode, input bit noise,
                             input int start_extra_spk, input int abort_beat);
        int cyc, spk, wait_cnt, resp_cyc, budget;
        bit pending;
        obs_beats.delete();
        obs_beat_spk.delete();
        obs_last_cnt = 0; obs_last_bad = 0; obs_cbsel_bad = 0; obs_gap_bad = 0;
        obs_done_cnt = 0; obs_resp_cnt = 0; obs_done_cyc = -1; obs_timeout = 0;
        obs_busy1 = 1'bx;
        spk = 0; pending = 0; wait_cnt = 0; resp_cyc = -100;
        budget = 200 + fn * NSPK * 4;
        for (cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            start      = (cyc == 0);
            frame_num  = MFW'(fn);
            dist_valid = 1'b0;
            dist_data  = 30'($urandom);
            case (ready_mode)
                0:       dist_ready = 1'b1;
                1:       dist_ready = (cyc % 2) == 1;
                default: dist_ready = 1'($urandom_range(0, 1));
            endcase
            if (pending) begin
                if (wait_cnt == 0) begin
                    dist_valid = 1'b1;
                    dist_data  = dists[spk];
                    pending    = 0;
                    resp_cyc   = cyc;
                    spk++;
                    obs_resp_cnt++;
                end else begin
                    wait_cnt--;
                    if (spk == start_extra_spk) begin
                        start     = 1'b1;
                        frame_num = MFW'(1);
                    end
                end
            end else if (noise && $urandom_range(0, 3) == 0) begin
                dist_valid = 1'b1;
                dist_data  = '0;
            end
            #1;
            if (cyc == 1) obs_busy1 = busy;
            if (pending && cb_sel !== 2'(spk)) obs_cbsel_bad++;
            if (cfg_valid) begin
                obs_beats.push_back(int'(cfg_data));
                obs_beat_spk.push_back(spk);
                if (cb_sel !== 2'(spk)) obs_cbsel_bad++;
                if (cfg_data == '0 && ready_mode == 0)
                    if (cyc != ((spk == 0) ? 1 : resp_cyc + 3)) obs_gap_bad++;
                if (cfg_last) begin
                    obs_last_cnt++;
                    if (int'(cfg_data) != fn - 1) obs_last_bad++;
                    pending  = 1;
                    wait_cnt = (spk == start_extra_spk) ? 3 : $urandom_range(0, 4);
                end else if (int'(cfg_data) == fn - 1) begin
                    obs_last_bad++;
                end
                if (abort_beat >= 0 && int'(cfg_data) == abort_beat) begin
                    rst_n = 1'b0;
                    start = 1'b0;
                    dist_valid = 1'b0;
                    return;
                end
            end
            if (done) begin
                obs_done_cnt++;
                obs_done_cyc     = cyc;
                obs_spk          = spk_id;
                obs_best         = best_dist;
                obs_err          = err;
                obs_busy_at_done = busy;
                break;
            end
        end
        if (cyc >= budget) obs_timeout = 1;
        start      = 1'b0;
        dist_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dist_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b want 0", done); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %0b want 0", err); end
        vectors++; if (cfg_valid !== 1'b0) begin miscompares++; $display("FAIL reset_cfg_valid got %0b want 0", cfg_valid); end
        vectors++; if (cfg_last !== 1'b0) begin miscompares++; $display("FAIL reset_cfg_last got %0b want 0", cfg_last); end
        vectors++; if (cfg_data !== '0) begin miscompares++; $display("FAIL reset_cfg_data got %0d want 0", cfg_data); end
        vectors++; if (cb_sel !== 2'd0) begin miscompares++; $display("FAIL reset_cb_sel got %0d want 0", cb_sel); end
        vectors++; if (spk_id !== 2'd0) begin miscompares++; $display("FAIL reset_spk_id got %0d want 0", spk_id); end
        vectors++; if (best_dist !== '0) begin miscompares++; $display("FAIL reset_best_dist got %0d want 0", best_dist); end
        vectors++; if (cfg_mode_data !== 6'(2 * 16 + CBC - 1)) begin miscompares++; $display("FAIL cfg_mode_data got %0h want %0h", cfg_mode_data, 6'(2 * 16 + CBC - 1)); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset checked");
    endtask

    task automatic check_job(input string name, input int fn);
        logic [1:0] e_spk; logic [29:0] e_best; logic e_err; int bad;
        ref_result(fn, e_spk, e_best, e_err);
        bad = 0;
        if (obs_beats.size() != fn * NSPK) bad = 1;
        else for (int i = 0; i < fn * NSPK; i++)
            if (obs_beats[i] != i % fn || obs_beat_spk[i] != i / fn) bad = 1;
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL %s_beats got %0d beats want %0d in order", name, obs_beats.size(), fn * NSPK); end
        vectors++; if (obs_timeout || obs_done_cnt != 1) begin miscompares++; $display("FAIL %s_done_count got %0d want 1", name, obs_done_cnt); end
        vectors++; if (obs_spk !== e_spk) begin miscompares++; $display("FAIL %s_spk_id got %0d want %0d", name, obs_spk, e_spk); end
        vectors++; if (obs_best !== e_best) begin miscompares++; $display("FAIL %s_best_dist got %0d want %0d", name, obs_best, e_best); end
        vectors++; if (obs_err !== e_err) begin miscompares++; $display("FAIL %s_err got %0b want %0b", name, obs_err, e_err); end
        vectors++; if (obs_busy_at_done !== 1'b0) begin miscompares++; $display("FAIL %s_busy_at_done got %0b want 0", name, obs_busy_at_done); end
        vectors++; if (obs_last_cnt != ((fn == 0) ? 0 : NSPK) || obs_last_bad != 0) begin miscompares++; $display("FAIL %s_cfg_last got %0d strobes %0d misplaced want %0d", name, obs_last_cnt, obs_last_bad, NSPK); end
        vectors++; if (obs_cbsel_bad != 0 || obs_gap_bad != 0) begin miscompares++; $display("FAIL %s_cb_sel_timing got %0d cb_sel and %0d gap errors want 0", name, obs_cbsel_bad, obs_gap_bad); end
        $display("job %s fn=%0d spk_id=%0d best_dist=%0d err=%0b", name, fn, obs_spk, obs_best, obs_err);
    endtask

    task automatic test_directed();
        dists[0] = 30'd500; dists[1] = 30'd200; dists[2] = 30'd300; dists[3] = 30'd200;
        drive_job(3, 0, 1'b0, -1, -1);
        check_job("directed", 3);
        vectors++; if (obs_busy1 !== 1'b1) begin miscompares++; $display("FAIL directed_busy_after_start got %0b want 1", obs_busy1); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < NSPK; i++) dists[i] = 30'($urandom_range(1000, 2000));
        drive_job(5, 1, 1'b0, -1, -1);
        check_job("stall", 5);
    endtask

    task automatic test_zero();
        drive_job(0, 0, 1'b0, -1, -1);
        check_job("zero", 0);
        vectors++; if (obs_done_cyc != 1) begin miscompares++; $display("FAIL zero_done_cycle got %0d want 1", obs_done_cyc); end
    endtask

    task automatic test_start_ignored();
        int extra_done;
        for (int i = 0; i < NSPK; i++) dists[i] = 30'($urandom_range(0, 50));
        drive_job(4, 0, 1'b0, 1, -1);
        check_job("start_ignored", 4);
        extra_done = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (done || busy) extra_done++;
        end
        vectors++; if (extra_done != 0) begin miscompares++; $display("FAIL start_ignored_idle got %0d active cycles want 0", extra_done); end
    endtask

    task automatic test_reset_midjob();
        int seen;
        for (int i = 0; i < NSPK; i++) dists[i] = 30'($urandom_range(10, 90));
        drive_job(6, 0, 1'b0, -1, 2);
        #1;
        vectors++; if (obs_done_cnt != 0) begin miscompares++; $display("FAIL midreset_early_done got %0d want 0", obs_done_cnt); end
        vectors++; if ({busy, done, err, cfg_valid, cfg_last} !== 5'b0) begin miscompares++; $display("FAIL midreset_flags got %05b want 00000", {busy, done, err, cfg_valid, cfg_last}); end
        vectors++; if ({cfg_data, cb_sel, spk_id, best_dist} !== '0) begin miscompares++; $display("FAIL midreset_data got %0d/%0d/%0d/%0d want 0", cfg_data, cb_sel, spk_id, best_dist); end
        seen = 0;
        repeat (3) begin @(negedge clk); #1; if (done) seen++; end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin @(negedge clk); #1; if (done) seen++; end
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL midreset_no_done got %0d strobes want 0", seen); end
        drive_job(6, 0, 1'b0, -1, -1);
        check_job("after_reset", 6);
    endtask

    task automatic test_random();
        int fn, mode;
        for (int j = 0; j < 8; j++) begin
            fn   = $urandom_range(1, 12);
            mode = $urandom_range(0, 2);
            for (int i = 0; i < NSPK; i++)
                dists[i] = ($urandom_range(0, 2) == 0) ? 30'($urandom_range(100, 102)) : 30'($urandom);
            drive_job(fn, mode, 1'b1, -1, -1);
            check_job("random", fn);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_zero();
        test_start_ignored();
        test_reset_midjob();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/disteu_match_ctrl.md
DISTEU_MATCH_CTRL -- requirements
Module: disteu_match_ctrl

Interface
REQ-001 SHALL have parameter MEAN_FRAME_WIDTH, default 9, width of frame index and frame count.
REQ-002 SHALL have parameter NUM_SPK, default 4, number of speaker codebooks compared.
REQ-003 SHALL have parameter CB_COLS, default 16, codebook columns per speaker (range 1..16).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 65535, watchdog limit in cycles.
REQ-005 SHALL provide ports: clk  in  1  single clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL provide ports: start  in  1  one-cycle job request; frame_num  in  MEAN_FRAME_WIDTH  frames to score.
REQ-007 SHALL provide ports: busy  out  1  job active; done  out  1  one-cycle result strobe; err  out  1  valid with done.
REQ-008 SHALL provide ports: spk_id  out  clog2(NUM_SPK)  winning speaker; best_dist  out  30  winning distance.
REQ-009 SHALL provide ports: cb_sel  out  clog2(NUM_SPK)  selects speaker codebook RAM feeding disteu r-port.
REQ-010 SHALL provide ports: cfg_valid  out  1; cfg_data  out  MEAN_FRAME_WIDTH; cfg_last  out  1; cfg_mode_data  out  6.
REQ-011 SHALL provide ports: dist_ready  in  1  (disteu o_ready); dist_valid  in  1; dist_data  in  30.

Function
REQ-012 SHALL drive cfg_mode_data constantly as {2'b10, CB_COLS-1} (many-to-many, per-row minimum summed).
REQ-013 SHALL implement states IDLE, CFG, WAIT_RES, COMPARE, DONE.
REQ-014 IDLE: on start, latch frame_num, clear speaker counter k=0, assert busy next cycle, go CFG; start while busy SHALL be ignored.
REQ-015 IDLE with start and frame_num==0 SHALL go DONE with err=1, spk_id=0, best_dist=0, no cfg beats.
REQ-016 CFG: beat i SHALL present cfg_data=i, cfg_valid=1; beat advances only in cycles where dist_ready=1.
REQ-017 CFG: cfg_last SHALL be 1 exactly on beat i=frame_num-1, coincident with cfg_valid; next state WAIT_RES.
REQ-018 cfg_valid SHALL be held 0 while dist_ready=0; frame index SHALL not advance on stalled cycles.
REQ-019 cb_sel SHALL equal k from CFG entry until COMPARE exit and be stable during WAIT_RES.
REQ-020 WAIT_RES: on dist_valid=1, capture dist_data, go COMPARE; dist_valid in any other state SHALL be ignored.
REQ-021 COMPARE: if k==0 or captured < best, best=captured, best_id=k (strict less-than; ties keep lower k).
REQ-022 COMPARE: if k==NUM_SPK-1 go DONE, else k=k+1, go CFG after one idle cycle (disteu INIT gap).
REQ-023 DONE: done=1 for one cycle with spk_id=best_id, best_dist=best, err=0; busy drops same cycle; return IDLE.
REQ-024 spk_id/best_dist SHALL hold last result until next done.
REQ-025 Latency per speaker SHALL be frame_num CFG beats plus disteu compute time plus 2 cycles.

Reset
REQ-026 rst_n low SHALL force IDLE, busy=0, done=0, err=0, cfg_valid=0, cfg_last=0, cfg_data=0, cb_sel=0, spk_id=0, best_dist=0.
REQ-027 Reset mid-job SHALL abandon the job with no done strobe.

Configuration
REQ-028 With DISTEU_CTRL_TIMEOUT_EN defined, a cycle counter SHALL run in CFG and WAIT_RES, clear on state entry and on each accepted beat.
REQ-029 With DISTEU_CTRL_TIMEOUT_EN, reaching TIMEOUT_CYC SHALL go DONE with err=1, spk_id=best_id so far, best_dist=best so far.
REQ-030 Without DISTEU_CTRL_TIMEOUT_EN, no counter exists and CFG/WAIT_RES wait indefinitely.

Structure
REQ-031 disteu_pkg SHALL hold state encoding, mode constants (2'b00, 2'b01, 2'b10) and 30-bit distance width.
REQ-032 One sub-module disteu_min_track SHALL hold best/best_id compare-and-update logic.

Verification
REQ-033 frame_num=3, NUM_SPK=4, dist_data 500,200,300,200 -> beats 0,1,2 with cfg_last on 2, four jobs, done: spk_id=1, best_dist=200.
REQ-034 dist_ready toggling 1/0 each cycle during CFG, frame_num=5 -> exactly five beats, indices 0..4, no duplicates.
REQ-035 frame_num=0 start -> done next cycle-pair with err=1, cfg_valid never asserted.
REQ-036 start pulsed during WAIT_RES -> ignored, single done at end of original job.
REQ-037 rst_n low during CFG beat 2 -> all outputs at reset values, no done; new start runs full job.
REQ-038 DISTEU_CTRL_TIMEOUT_EN, TIMEOUT_CYC=100, dist_valid withheld for speaker 2 -> done at 100 cycles, err=1, spk_id = best of speakers 0..1.
